// File: rtl/servo_value_uart_tx.sv
// servo_value_uart_tx
// Echoes a 20-bit servo value to the host as 7 ASCII decimal digits plus CR LF.
// The UART format is 8N1. Binary-to-BCD conversion is a sequential double-dabble,
// one iteration per clock.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   value_i  unsigned value to transmit, sampled on the accept edge
//   valid_i  request; accepted when valid_i && ready_o
//   ready_o  high while idle and able to accept (registered)
//   tx_o     UART serial line, idle high (registered)
module servo_value_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned DATA_W       = 20,
    parameter int unsigned DIGITS       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned TMR_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned ITER_W = $clog2(DATA_W + 1);
    localparam int unsigned NBYTES = DIGITS + 2;
    localparam int unsigned BYTE_W = $clog2(NBYTES + 1);

    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DATA_W - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);
    localparam logic [3:0]        BIT_LAST  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_SEND    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [BCD_W-1:0]    bcd_adj;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [3:0]          bit_q, bit_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic                ready_q, ready_d;
    logic                tx_q, tx_d;
    logic                accept;
    logic [7:0]          cur_byte;
    logic [9:0]          frame;

    assign accept  = valid_i && ready_q;
    assign ready_o = ready_q;
    assign tx_o    = tx_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            tmr_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            ready_q <= 1'b1;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            ready_q <= ready_d;
            tx_q    <= tx_d;
        end
    end

    // Next state: conversion steps and bit/byte sequencing
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        bcd_adj = bcd_q;

        // Double-dabble correction: any digit >= 5 gets +3 before the shift
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    bin_d   = value_i;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_LAST) begin
                    iter_d  = '0;
                    tmr_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // Counters name the bit being registered onto tx this cycle
                if (tmr_q == TMR_LAST) begin
                    tmr_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (byte_q == BYTE_LAST) begin
                            byte_d  = '0;
                            state_d = S_IDLE;
                        end else begin
                            byte_d = byte_q + BYTE_W'(1);
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: character selection and the next registered line level
    always_comb begin
        cur_byte = 8'h0A;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (byte_q == BYTE_W'(i)) begin
                cur_byte = 8'h30 + {4'h0, bcd_q[4*(int'(DIGITS)-1-i) +: 4]};
            end
        end
        if (byte_q == BYTE_W'(DIGITS)) begin
            cur_byte = 8'h0D;
        end

        frame   = {1'b1, cur_byte, 1'b0};
        ready_d = (state_q == S_IDLE) && !accept;
        tx_d    = 1'b1;
        if (state_q == S_SEND) begin
            tx_d = frame[bit_q];
        end
    end

endmodule
